apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB responder that terminates one peripheral select of the AHB-to-APB bridge and gives the bridge real read data and write sinks in place of the passive APB model. It holds a small word-addressed register file and runs the APB SETUP/ACCESS handshake with optional wait states. It reports out-of-range or misaligned accesses through `pslverr` and keeps saturating read/write transfer counters for bench and debug visibility.

## Interface
- `SLAVE_ID`, default 0: which `psel` bit (0..2) this instance answers.
- `DEPTH`, default 16: number of 32-bit registers; power of two, 2..256.
- `WAIT_STATES`, default 0: extra ACCESS cycles before `pready`. A value of 0 is APB2-compatible with the existing bridge.
- `hclk` input 1: single clock for all logic.
- `hreset` input 1: reset; synchronous and active-high.
- `psel` input 3: one-hot peripheral select from the bridge.
- `penable` input 1: APB enable (ACCESS phase).
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input 32: byte address. Word index is `paddr[log2(DEPTH)+1:2]`; offset is `paddr[25:2]` within the 64 MB select window.
- `pwdata` input 32: write data.
- `pr_data` output 32: read data. Valid only while `pready` is high on a read ACCESS; 0 otherwise.
- `pready` output 1: transfer completes this cycle.
- `pslverr` output 1: error response, valid with `pready`.
- `wr_count` output 16: completed good writes, saturating.
- `rd_count` output 16: completed good reads, saturating.

## Operation
- **Selection:**
  - "sel" means `psel[SLAVE_ID]`.
  - Other `psel` bits are ignored, including illegal multi-hot patterns.
- **States:** IDLE, SETUP, ACCESS.
  - IDLE -> SETUP: when sel=1 and `penable`=0. The cycle in which that is observed is the setup cycle.
  - SETUP -> ACCESS: unconditional after one cycle. At this transition, latch `pwrite`, the word index, `pwdata`, the error flag and the read word (`mem[index]`, or 0 if in error); load the wait counter with `WAIT_STATES`.
  - ACCESS: decrement the wait counter while it is nonzero. `pready`=1 when the counter is 0 and `penable`=1.
  - ACCESS completion: on the `pready` edge, go to SETUP if sel=1 and `penable`=0 in that cycle, otherwise to IDLE.
  - ACCESS with sel dropped before `pready`: return to IDLE with no commit and no count (protocol abort).
- **Error condition:** `paddr[1:0]` != 0, or offset >= `DEPTH`.
  - On error: write is ignored, read returns 0, `pslverr`=1 with `pready`, and no counter increments.
- **Commit:** a good write updates `mem[index]` on the completing edge.
  - A read in the immediately following transfer returns the new value.
- **Counters:** increment by 1 on each good completing transfer and hold at 0xFFFF.
- **Reset (any state, including mid-transfer):**
  - State goes to IDLE, the in-flight transfer is dropped, all `mem` words are cleared to 0, and both counters are cleared.
  - `pr_data`=0, `pready`=0, `pslverr`=0 during and after reset until a new ACCESS.

## Timing
- With `WAIT_STATES`=0:
  - Setup cycle T: sel=1, `penable`=0.
  - Cycle T+1: `penable`=1, `pready`=1, `pr_data`/`pslverr` valid. A write is committed at the end of T+1.
- With `WAIT_STATES`=N: `pready` rises in cycle T+1+N. `pr_data` is stable from T+1 until completion.
- Latency from setup cycle to completion: 1+N cycles. Back-to-back transfers need no idle cycle.
- Outputs `pready`, `pslverr` and `pr_data` are decoded from registered state and the latched transfer. No combinational path from `paddr` or `pwdata` to outputs.

## Structure
- Shared package `apb_pkg`:
  - state enum (IDLE, SETUP, ACCESS);
  - `APB_DATA_W`=32;
  - select window bases `32'h8000_0000`, `32'h8400_0000`, `32'h8800_0000`;
  - offset field bounds [25:2].
- One sub-module, `apb_wait_timer`: load/decrement/zero-flag counter for wait states. The register file and FSM stay in the top module.

## Test plan
- **Reset/write/read, `WAIT_STATES`=0:** reset, write `0xDEAD_BEEF` to `0x8000_0008`, read `0x8000_0008`.
  - Each transfer completes 1 cycle after setup.
  - Read returns `0xDEAD_BEEF`; `wr_count`=1, `rd_count`=1; `pslverr`=0.
- **Back-to-back:** write `0x1234_5678` to `0x8000_0004`, then immediately read it with no idle cycle. Read returns `0x1234_5678`.
- **Wait states, `WAIT_STATES`=3:** read `0x8000_0000` after reset. `pready` is high only in cycle T+4; `pr_data`=0.
- **Errors:**
  - write to `0x8000_0042` (misaligned) -> `pslverr`=1, memory unchanged;
  - write to `0x8000_0040` with `DEPTH`=16 -> `pslverr`=1;
  - read of `0x8000_0040` -> `pr_data`=0, `pslverr`=1;
  - in all cases counters are unchanged.
- **Foreign select and abort:**
  - `psel`=3'b010 on the `SLAVE_ID`=0 instance -> no `pready`, no state change.
  - `hreset` asserted during ACCESS of a write to `0x8000_000C` -> next read of `0x8000_000C` returns 0 and counters are 0.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state encoding, bus width, select windows and counter helper
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  localparam int APB_DATA_W = 32;
  localparam logic [31:0] SEL_BASE0 = 32'h8000_0000;
  localparam logic [31:0] SEL_BASE1 = 32'h8400_0000;
  localparam logic [31:0] SEL_BASE2 = 32'h8800_0000;
  localparam int OFF_LO = 2;
  localparam int OFF_HI = 25;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v == 16'hffff ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: loadable down-counter that flags when the wait-state budget is spent
module apb_wait_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (en && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB register file responder with wait states, error response and saturating transfer counters
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int SLAVE_ID    = 0,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [2:0]            psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_DATA_W-1:0] pr_data,
  output logic                  pready,
  output logic                  pslverr,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  apb_state_t state, phase;
  logic [APB_DATA_W-1:0] mem [DEPTH];
  logic [APB_DATA_W-1:0] wd_l, rd_l;
  logic [AW-1:0] idx_l;
  logic wr_l, err_l, sel, bad, zero, unused;
  assign sel = psel[SLAVE_ID];
  assign bad = |paddr[1:0] || paddr[OFF_HI:OFF_LO] >= 24'(DEPTH);
  // SETUP is the cycle the request is seen; the transfer is captured at its end so ACCESS starts next cycle
  assign phase = (state != ACCESS && sel && !penable) ? SETUP : state;
  assign pready = !hreset && state == ACCESS && zero && penable;
  assign pslverr = pready && err_l;
  assign pr_data = (pready && !wr_l) ? rd_l : '0;
  assign unused = ^{psel, paddr[31:OFF_HI+1]};
  apb_wait_timer #(.W(TW)) u_timer (
    .clk (hclk),
    .rst (hreset),
    .load(phase == SETUP),
    .en  (state == ACCESS),
    .val (TW'(WAIT_STATES)),
    .zero(zero)
  );
  always_ff @(posedge hclk)
    if (hreset) begin
      state <= IDLE;
      wr_l <= 1'b0;
      err_l <= 1'b0;
      idx_l <= '0;
      wd_l <= '0;
      rd_l <= '0;
      wr_count <= '0;
      rd_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (phase == SETUP) begin
        state <= ACCESS;
        wr_l <= pwrite;
        err_l <= bad;
        idx_l <= paddr[AW+1:2];
        wd_l <= pwdata;
        rd_l <= bad ? '0 : mem[paddr[AW+1:2]];
      end else if (state == ACCESS && (pready || !sel)) state <= IDLE;
      if (pready && !err_l) begin
        if (wr_l) begin
          mem[idx_l] <= wd_l;
          wr_count <= sat_inc(wr_count);
        end else rd_count <= sat_inc(rd_count);
      end
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: table, directed and randomized checks of two responders (0 and 3 wait states) on one bus
module tb_apb_slave_regfile;
  import apb_pkg::*;
  logic hclk = 1'b0, hreset;
  logic [2:0] psel;
  logic penable, pwrite;
  logic [31:0] paddr, pwdata, prd0, prd3;
  logic rdy0, rdy3, err0, err3;
  logic [15:0] wc0, rc0, wc3, rc3;
  int n_tests = 0, n_fail = 0;
  logic [31:0] m [2][16];
  int wcm [2], rcm [2];
  typedef struct {bit w; logic [31:0] a, d, rd; bit er; int wc, rc; bit gap;} vec_t;
  vec_t tbl [9];

  always #5 hclk = ~hclk;

  apb_slave_regfile #(.SLAVE_ID(0), .DEPTH(16), .WAIT_STATES(0)) u0 (
    .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pr_data(prd0), .pready(rdy0), .pslverr(err0),
    .wr_count(wc0), .rd_count(rc0));
  apb_slave_regfile #(.SLAVE_ID(1), .DEPTH(16), .WAIT_STATES(3)) u3 (
    .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pr_data(prd3), .pready(rdy3), .pslverr(err3),
    .wr_count(wc3), .rd_count(rc3));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic get_rdy(input int s);
    return s == 0 ? rdy0 : rdy3;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      wcm[s] = 0;
      rcm[s] = 0;
      for (int i = 0; i < 16; i++) m[s][i] = 0;
    end
  endtask

  task automatic model(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output bit er);
    er = a[1:0] != 0 || a[25:2] >= 16;
    rd = 0;
    if (!er) begin
      if (w) begin
        m[s][a[5:2]] = d;
        if (wcm[s] < 65535) wcm[s]++;
      end else begin
        rd = m[s][a[5:2]];
        if (rcm[s] < 65535) rcm[s]++;
      end
    end
  endtask

  task automatic idle();
    psel = 3'b000;
    penable = 1'b0;
    @(posedge hclk); #1;
  endtask

  task automatic xfer(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    psel = s == 0 ? 3'b001 : 3'b010;
    penable = 1'b0;
    pwrite = w;
    paddr = a;
    pwdata = d;
    lat = 0;
    do begin
      @(posedge hclk); #1;
      penable = 1'b1;
      lat++;
      @(negedge hclk);
    end while (!get_rdy(s) && lat < 20);
    if (!get_rdy(s)) chk("ready_timeout", 32'(get_rdy(s)), 32'd1);
    rd = s == 0 ? prd0 : prd3;
    er = s == 0 ? err0 : err3;
    @(posedge hclk); #1;
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_wc0"}, 32'(wc0), 32'(wcm[0]));
    chk({nm, "_rc0"}, 32'(rc0), 32'(rcm[0]));
    chk({nm, "_wc3"}, 32'(wc3), 32'(wcm[1]));
    chk({nm, "_rc3"}, 32'(rc3), 32'(rcm[1]));
  endtask

  task automatic run(input string nm, input int s, input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] erd, rd;
    bit eer;
    logic er;
    int lat;
    model(s, w, a, d, erd, eer);
    xfer(s, w, a, d, rd, er, lat);
    chk({nm, "_rdata"}, rd, erd);
    chk({nm, "_slverr"}, 32'(er), 32'(eer));
    chk({nm, "_latency"}, 32'(lat), s == 0 ? 32'd1 : 32'd4);
    chk_counts(nm);
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    psel = 3'b000;
    penable = 1'b0;
    @(negedge hclk);
    chk("rst_outputs0", {prd0[30:0], rdy0}, 32'd0);
    chk("rst_outputs3", {prd3[30:0], rdy3}, 32'd0);
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    clear_model();
    @(negedge hclk);
    chk("post_rst_flags", {28'd0, rdy0, err0, rdy3, err3}, 32'd0);
    chk("post_rst_rdata", prd0 | prd3, 32'd0);
    chk_counts("post_rst");
    @(posedge hclk); #1;
  endtask

  initial begin
    logic [31:0] rd, erd, a, off;
    logic er;
    bit eer, seen0;
    int lat, s, r;
    hreset = 1'b1;
    psel = 3'b000;
    penable = 1'b0;
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
    do_reset();

    run("ws3_read", 1, 1'b0, SEL_BASE1, 32'h0);

    tbl[0] = '{1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0,         1'b0, 1, 0, 1'b1};
    tbl[1] = '{1'b0, 32'h8000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, 1, 1'b1};
    tbl[2] = '{1'b1, 32'h8000_0004, 32'h1234_5678, 32'h0,         1'b0, 2, 1, 1'b0};
    tbl[3] = '{1'b0, 32'h8000_0004, 32'h0,         32'h1234_5678, 1'b0, 2, 2, 1'b1};
    tbl[4] = '{1'b1, 32'h8000_0042, 32'hAAAA_5555, 32'h0,         1'b1, 2, 2, 1'b0};
    tbl[5] = '{1'b1, 32'h8000_0040, 32'hBBBB_CCCC, 32'h0,         1'b1, 2, 2, 1'b0};
    tbl[6] = '{1'b0, 32'h8000_0040, 32'h0,         32'h0,         1'b1, 2, 2, 1'b0};
    tbl[7] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b0, 2, 3, 1'b0};
    tbl[8] = '{1'b0, 32'h8000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 4, 1'b1};
    for (int i = 0; i < 9; i++) begin
      model(0, tbl[i].w, tbl[i].a, tbl[i].d, erd, eer);
      xfer(0, tbl[i].w, tbl[i].a, tbl[i].d, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_slverr", i), 32'(er), 32'(tbl[i].er));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
      chk($sformatf("vec%0d_wr_count", i), 32'(wc0), 32'(tbl[i].wc));
      chk($sformatf("vec%0d_rd_count", i), 32'(rc0), 32'(tbl[i].rc));
      if (tbl[i].gap) idle();
    end

    seen0 = 1'b0;
    pwrite = 1'b0;
    paddr = SEL_BASE1 | 32'h2;
    for (int k = 0; k < 2; k++) begin
      psel = k == 0 ? 3'b010 : 3'b110;
      penable = 1'b0;
      @(negedge hclk);
      seen0 |= rdy0;
      for (int c = 0; c < 5; c++) begin
        @(posedge hclk); #1;
        penable = 1'b1;
        @(negedge hclk);
        seen0 |= rdy0;
      end
      @(posedge hclk); #1;
    end
    idle();
    chk("foreign_sel_no_ready", 32'(seen0), 32'd0);
    chk_counts("foreign_sel");
    run("after_foreign", 0, 1'b0, SEL_BASE0 | 32'h8, 32'h0);

    for (int i = 0; i < 300; i++) begin
      s = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      off = r == 0 ? $urandom_range(0, 15) * 4 + $urandom_range(1, 3)
          : r == 1 ? $urandom_range(16, 1000) * 4 : $urandom_range(0, 15) * 4;
      a = (s == 0 ? SEL_BASE0 : SEL_BASE1) | off;
      run($sformatf("rnd%0d", i), s, 1'(($urandom_range(0, 1))), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end

    run("pre_abort_wr", 0, 1'b1, SEL_BASE0 | 32'hC, 32'h5A5A_A5A5);
    psel = 3'b001;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = SEL_BASE0 | 32'hC;
    pwdata = 32'hCAFE_F00D;
    @(posedge hclk); #1;
    penable = 1'b1;
    hreset = 1'b1;
    @(negedge hclk);
    chk("abort_rst_pready", 32'(rdy0), 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    psel = 3'b000;
    penable = 1'b0;
    clear_model();
    @(negedge hclk);
    chk_counts("abort_rst");
    @(posedge hclk); #1;
    run("abort_readback", 0, 1'b0, SEL_BASE0 | 32'hC, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
